vx_mem_tag_table: RTL and testbench

Pending-request tag table placed directly downstream of the cache arbiter's request output and upstream of its response input. It replaces each wide arbitrated read tag (requester index plus original tag) with a small table index before the memory port, stores the wide tag, and restores it on the matching response. Writes pass through without allocation because they produce no response. The block bounds outstanding reads to `NUM_ENTRIES` and narrows the tag carried by the memory interface.

---
 rtl/vx_mem_tag_table.sv | 132 +++++++++++++
 tb/tb_vx_mem_tag_table.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_tag_table.sv
// ============================================================================
// vx_mem_tag_table: narrows arbitrated read tags to table indices and
// restores the wide tag on the matching memory response.   Rev 1.0
// ============================================================================
`default_nettype none

module vx_mem_tag_table #(
  parameter  int NUM_ENTRIES  = 8,
  parameter  int TAG_IN_WIDTH = 8,
  parameter  int DATA_SIZE    = 4,
  localparam int ID_WIDTH     = $clog2(NUM_ENTRIES),
  localparam int DATA_WIDTH   = 8 * DATA_SIZE,
  localparam int ADDR_WIDTH   = 32 - $clog2(DATA_SIZE),
  localparam int SIZE_WIDTH   = $clog2($clog2(DATA_SIZE) + 1)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req_valid_in,
  input  logic                    req_rw_in,
  input  logic [DATA_SIZE-1:0]    req_byteen_in,
  input  logic [SIZE_WIDTH-1:0]   req_size_in,
  input  logic [ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [DATA_WIDTH-1:0]   req_data_in,
  input  logic [TAG_IN_WIDTH-1:0] req_tag_in,
  output logic                    req_ready_in,

  output logic                    req_valid_out,
  output logic                    req_rw_out,
  output logic [DATA_SIZE-1:0]    req_byteen_out,
  output logic [SIZE_WIDTH-1:0]   req_size_out,
  output logic [ADDR_WIDTH-1:0]   req_addr_out,
  output logic [DATA_WIDTH-1:0]   req_data_out,
  output logic [ID_WIDTH-1:0]     req_tag_out,
  input  logic                    req_ready_out,

  input  logic                    rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]   rsp_data_in,
  input  logic [ID_WIDTH-1:0]     rsp_tag_in,
  output logic                    rsp_ready_in,

  output logic                    rsp_valid_out,
  output logic [DATA_WIDTH-1:0]   rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0] rsp_tag_out,
  input  logic                    rsp_ready_out,

  output logic [ID_WIDTH:0]       pending_count,
  output logic                    full
);

  localparam logic [ID_WIDTH:0] FULL_COUNT = (ID_WIDTH + 1)'(NUM_ENTRIES);
  localparam logic [ID_WIDTH:0] COUNT_ONE  = (ID_WIDTH + 1)'(1);

  logic [NUM_ENTRIES-1:0]  valid_mask;
  logic [TAG_IN_WIDTH-1:0] tag_store [NUM_ENTRIES];

  logic                reg_free;
  logic                req_fire;
  logic                read_fire;
  logic                rsp_fire;
  logic                release_fire;
  logic [ID_WIDTH-1:0] alloc_idx;

  assign reg_free     = !req_valid_out || req_ready_out;
  assign req_ready_in = reset && reg_free && (req_rw_in || !full);
  assign req_fire     = req_valid_in && req_ready_in;
  assign read_fire    = req_fire && !req_rw_in;

  assign rsp_valid_out = rsp_valid_in;
  assign rsp_ready_in  = rsp_ready_out;
  assign rsp_data_out  = rsp_data_in;
  assign rsp_tag_out   = tag_store[rsp_tag_in];
  assign rsp_fire      = rsp_valid_in && rsp_ready_out;
  // A response to an idle entry must not underflow the count.
  assign release_fire  = rsp_fire && valid_mask[rsp_tag_in];

  assign full = (pending_count == FULL_COUNT);

  // Lowest free entry of the pre-release mask.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        alloc_idx = ID_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_mask    <= '0;
      pending_count <= '0;
      req_valid_out <= 1'b0;
    end else begin
      if (release_fire) begin
        valid_mask[rsp_tag_in] <= 1'b0;
      end
      if (read_fire) begin
        valid_mask[alloc_idx] <= 1'b1;
      end
      case ({read_fire, release_fire})
        2'b10:   pending_count <= pending_count + COUNT_ONE;
        2'b01:   pending_count <= pending_count - COUNT_ONE;
        default: pending_count <= pending_count;
      endcase
      if (reg_free) begin
        req_valid_out <= req_fire;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (read_fire) begin
      tag_store[alloc_idx] <= req_tag_in;
    end
    if (req_fire) begin
      req_rw_out     <= req_rw_in;
      req_byteen_out <= req_byteen_in;
      req_size_out   <= req_size_in;
      req_addr_out   <= req_addr_in;
      req_data_out   <= req_data_in;
      req_tag_out    <= req_rw_in ? '0 : alloc_idx;
    end
  end

  rsp_to_allocated_entry : assert property (
    @(posedge clk) disable iff (!reset) rsp_fire |-> valid_mask[rsp_tag_in]
  );

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_tag_table.sv
// ============================================================================
// tb_vx_mem_tag_table: directed self-checking bench for vx_mem_tag_table.
// ============================================================================
`default_nettype none

module tb_vx_mem_tag_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_in, req_rw_in;
  logic [3:0]  req_byteen_in;
  logic [1:0]  req_size_in;
  logic [29:0] req_addr_in;
  logic [31:0] req_data_in;
  logic [7:0]  req_tag_in;
  logic        req_ready_in;
  logic        req_valid_out, req_rw_out;
  logic [3:0]  req_byteen_out;
  logic [1:0]  req_size_out;
  logic [29:0] req_addr_out;
  logic [31:0] req_data_out;
  logic [2:0]  req_tag_out;
  logic        req_ready_out;
  logic        rsp_valid_in;
  logic [31:0] rsp_data_in;
  logic [2:0]  rsp_tag_in;
  logic        rsp_ready_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_data_out;
  logic [7:0]  rsp_tag_out;
  logic        rsp_ready_out;
  logic [3:0]  pending_count;
  logic        full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_mem_tag_table #(.NUM_ENTRIES(8), .TAG_IN_WIDTH(8), .DATA_SIZE(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_size_in(req_size_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
    .req_size_out(req_size_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out),
    .pending_count(pending_count), .full(full)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic rw, input logic [7:0] tag);
    req_valid_in  = 1'b1;
    req_rw_in     = rw;
    req_tag_in    = tag;
    req_byteen_in = rw ? 4'h3 : 4'hF;
    req_size_in   = rw ? 2'd1 : 2'd2;
    req_addr_in   = 30'h100 + 30'(tag);
    req_data_in   = 32'hDA7A_0000 | 32'(tag);
  endtask

  // Present a read, let it be accepted on the next edge, check the registered output.
  task automatic do_read(input logic [7:0] tag, input logic [2:0] exp_idx);
    set_req(1'b0, tag);
    step();
    chk("rd_valid_out", req_valid_out, 1);
    chk("rd_rw_out", req_rw_out, 0);
    chk("rd_tag_out", req_tag_out, exp_idx);
    chk("rd_addr_out", req_addr_out, 30'h100 + 30'(tag));
  endtask

  task automatic idle();
    req_valid_in = 1'b0;
    step();
  endtask

  task automatic do_rsp(input logic [2:0] id, input logic [7:0] exp_tag);
    rsp_valid_in = 1'b1;
    rsp_tag_in   = id;
    rsp_data_in  = 32'h5A00_0000 | 32'(id);
    @(negedge clk);
    chk("rsp_valid_out", rsp_valid_out, 1);
    chk("rsp_data_out", rsp_data_out, 32'h5A00_0000 | 32'(id));
    chk("rsp_tag_out", rsp_tag_out, exp_tag);
    step();
    rsp_valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid_in = 1'b0; req_rw_in = 1'b0; req_byteen_in = '0; req_size_in = '0;
    req_addr_in = '0; req_data_in = '0; req_tag_in = '0; req_ready_out = 1'b1;
    rsp_valid_in = 1'b0; rsp_data_in = '0; rsp_tag_in = '0; rsp_ready_out = 1'b1;

    step();
    step();
    chk("rst_valid_out", req_valid_out, 0);
    chk("rst_pending", pending_count, 0);
    chk("rst_full", full, 0);
    @(negedge clk);
    chk("rst_ready_in", req_ready_in, 0);
    reset = 1'b1;
    step();

    // three back-to-back reads
    do_read(8'h11, 3'd0);
    chk("rd_byteen_out", req_byteen_out, 4'hF);
    chk("rd_data_out", req_data_out, 32'hDA7A_0011);
    do_read(8'h22, 3'd1);
    do_read(8'h33, 3'd2);
    idle();
    chk("pending_3", pending_count, 3);
    chk("drained_valid", req_valid_out, 0);

    // fill the table
    do_read(8'h44, 3'd3);
    do_read(8'h55, 3'd4);
    do_read(8'h66, 3'd5);
    do_read(8'h77, 3'd6);
    do_read(8'h88, 3'd7);
    idle();
    chk("pending_8", pending_count, 8);
    chk("full_set", full, 1);

    // ninth read stalls, write passes
    set_req(1'b0, 8'h99);
    @(negedge clk);
    chk("full_rd_ready", req_ready_in, 0);
    step();
    chk("full_rd_no_valid", req_valid_out, 0);
    chk("full_rd_pending", pending_count, 8);
    set_req(1'b1, 8'hEE);
    @(negedge clk);
    chk("full_wr_ready", req_ready_in, 1);
    step();
    chk("wr_valid_out", req_valid_out, 1);
    chk("wr_rw_out", req_rw_out, 1);
    chk("wr_tag_out", req_tag_out, 0);
    chk("wr_size_out", req_size_out, 2'd1);
    chk("wr_addr_out", req_addr_out, 30'h1EE);
    chk("wr_pending", pending_count, 8);
    idle();

    // out-of-order responses
    do_rsp(3'd5, 8'h66);
    do_rsp(3'd2, 8'h33);
    do_rsp(3'd7, 8'h88);
    chk("pending_5", pending_count, 5);
    chk("full_clear", full, 0);
    do_read(8'h9A, 3'd2);
    do_read(8'hA5, 3'd5);
    do_read(8'hA7, 3'd7);
    idle();
    chk("refill_full", full, 1);

    // response and read in the same cycle while full
    rsp_valid_in = 1'b1; rsp_tag_in = 3'd3; rsp_data_in = 32'h1234_5678;
    set_req(1'b0, 8'hB3);
    @(negedge clk);
    chk("same_rd_ready", req_ready_in, 0);
    chk("same_rsp_tag", rsp_tag_out, 8'h44);
    step();
    rsp_valid_in = 1'b0;
    chk("same_pending_7", pending_count, 7);
    chk("same_no_valid", req_valid_out, 0);
    @(negedge clk);
    chk("same_rd_ready_next", req_ready_in, 1);
    step();
    chk("same_rd_tag", req_tag_out, 3);
    chk("same_pending_8", pending_count, 8);
    idle();

    // downstream backpressure
    do_rsp(3'd0, 8'h11);
    do_rsp(3'd1, 8'h22);
    chk("pending_6", pending_count, 6);
    req_ready_out = 1'b0;
    do_read(8'hC0, 3'd0);
    set_req(1'b0, 8'hC1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready_in", req_ready_in, 0);
      step();
      chk("bp_valid_out", req_valid_out, 1);
      chk("bp_tag_out", req_tag_out, 0);
      chk("bp_addr_out", req_addr_out, 30'h1C0);
      chk("bp_pending", pending_count, 7);
    end
    req_ready_out = 1'b1;
    @(negedge clk);
    chk("bp_drain_ready", req_ready_in, 1);
    step();
    chk("bp_next_tag", req_tag_out, 1);
    chk("bp_next_addr", req_addr_out, 30'h1C1);
    chk("bp_pending_8", pending_count, 8);
    idle();
    chk("bp_idle_valid", req_valid_out, 0);
    do_rsp(3'd0, 8'hC0);

    // reset with outstanding entries and a held request
    req_ready_out = 1'b0;
    do_read(8'hCF, 3'd0);
    req_valid_in = 1'b0;
    reset = 1'b0;
    step();
    chk("mid_rst_pending", pending_count, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_valid", req_valid_out, 0);
    reset = 1'b1;
    req_ready_out = 1'b1;
    do_read(8'hD0, 3'd0);
    idle();
    chk("post_rst_pending", pending_count, 1);
    do_rsp(3'd0, 8'hD0);
    chk("post_rst_empty", pending_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
